// File: rtl/enable_ctrl.sv
// rtl/enable_ctrl.sv - run-length enable sequencer for the downstream up-counter
// Optional completed-run counter enabled by defining ENABLE_CTRL_STATUS_EN.
module enable_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic             repeat_mode,
    input  logic [LEN_W-1:0] run_len,
    input  logic [LEN_W-1:0] gap_len,
    output logic             enable,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [7:0]       run_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] gap_q, gap_d;
    logic             enable_q, enable_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             end_run;
    logic             run_completed;

    always_comb begin
        state_d   = state_q;
        remain_d  = remain_q;
        len_d     = len_q;
        gap_d     = gap_q;
        enable_d  = enable_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        end_run   = 1'b0;

        case (state_q)
            S_IDLE: begin
                enable_d = 1'b0;
                busy_d   = 1'b0;
                if (start) begin
                    if (run_len != '0) begin
                        len_d    = run_len;
                        gap_d    = gap_len;
                        remain_d = run_len;
                        state_d  = S_RUN;
                        enable_d = 1'b1;
                        busy_d   = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                remain_d = remain_q - LEN_W'(1);
                if (remain_q == LEN_W'(1)) begin
                    // A repeating run always gets at least one low cycle so the counter clears.
                    if ((gap_q != '0) || repeat_mode) begin
                        state_d  = S_GAP;
                        remain_d = (gap_q == '0) ? LEN_W'(1) : gap_q;
                        enable_d = 1'b0;
                    end else begin
                        end_run = 1'b1;
                    end
                end
            end
            S_GAP: begin
                remain_d = remain_q - LEN_W'(1);
                if (remain_q == LEN_W'(1)) begin
                    end_run = 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                enable_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase

        if (end_run) begin
            done_d = 1'b1;
            if (repeat_mode) begin
                state_d  = S_RUN;
                remain_d = len_q;
                enable_d = 1'b1;
                busy_d   = 1'b1;
            end else begin
                state_d  = S_IDLE;
                enable_d = 1'b0;
                busy_d   = 1'b0;
            end
        end

        // Abort outranks a coincident end-of-run: no done, no count.
        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            remain_d  = '0;
            enable_d  = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
            aborted_d = 1'b1;
        end
    end

    assign run_completed = done_d && (state_q != S_IDLE);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            remain_q  <= '0;
            len_q     <= '0;
            gap_q     <= '0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            remain_q  <= remain_d;
            len_q     <= len_d;
            gap_q     <= gap_d;
            enable_q  <= enable_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign enable  = enable_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign aborted = aborted_q;

`ifdef ENABLE_CTRL_STATUS_EN
    logic [7:0] run_count_q, run_count_d;

    always_comb begin
        run_count_d = run_count_q;
        if (run_completed && (run_count_q != 8'hFF)) begin
            run_count_d = run_count_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            run_count_q <= 8'd0;
        end else begin
            run_count_q <= run_count_d;
        end
    end

    assign run_count = run_count_q;
`else
    logic unused_run_completed;
    assign unused_run_completed = run_completed;
    assign run_count            = 8'd0;
`endif

endmodule

// File: tb/tb_enable_ctrl.sv
// tb/tb_enable_ctrl.sv - directed vector bench for enable_ctrl
// Run-count expectations follow ENABLE_CTRL_STATUS_EN.
module tb_enable_ctrl;

`ifdef ENABLE_CTRL_STATUS_EN
    localparam bit STATUS = 1'b1;
`else
    localparam bit STATUS = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       resetn, start, abort, repeat_mode;
    logic [7:0] run_len, gap_len;
    logic       enable, busy, done, aborted;
    logic [7:0] run_count;

    int n_pass  = 0;
    int n_total = 0;

    enable_ctrl #(.LEN_W(8)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .abort       (abort),
        .repeat_mode (repeat_mode),
        .run_len     (run_len),
        .gap_len     (gap_len),
        .enable      (enable),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .run_count   (run_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rstn;
        logic       st;
        logic       ab;
        logic       rep;
        logic [7:0] rl;
        logic [7:0] gl;
        logic       e_en;
        logic       e_busy;
        logic       e_done;
        logic       e_ab;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t tv[$];

    task automatic v(input logic rstn, input logic st, input logic ab, input logic rep,
                     input logic [7:0] rl, input logic [7:0] gl,
                     input logic en, input logic bsy, input logic dn, input logic abd,
                     input logic [7:0] cnt);
        vec_t r;
        r.rstn = rstn; r.st = st; r.ab = ab; r.rep = rep; r.rl = rl; r.gl = gl;
        r.e_en = en; r.e_busy = bsy; r.e_done = dn; r.e_ab = abd;
        r.e_cnt = STATUS ? cnt : 8'd0;
        tv.push_back(r);
    endtask

    task automatic drive(input logic rstn, input logic st, input logic ab, input logic rep,
                         input logic [7:0] rl, input logic [7:0] gl);
        resetn = rstn; start = st; abort = ab; repeat_mode = rep;
        run_len = rl; gap_len = gl;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got en/busy/done/ab/cnt=%h want %h", name, got, want);
    endtask

    initial begin
        int k;
        int dones;
        // reset
        v(0,0,0,0, 0,0,   0,0,0,0, 0);
        // basic run: 5 high, 3 low, done
        v(1,1,0,0, 5,3,   1,1,0,0, 0);
        for (int i = 0; i < 4; i++) v(1,0,0,0, 0,0, 1,1,0,0, 0);
        for (int i = 0; i < 3; i++) v(1,0,0,0, 0,0, 0,1,0,0, 0);
        v(1,0,0,0, 0,0,   0,0,1,0, 1);
        v(1,0,0,0, 0,0,   0,0,0,0, 1);
        // zero-length start
        v(1,1,0,0, 0,3,   0,0,1,0, 1);
        v(1,0,0,0, 0,0,   0,0,0,0, 1);
        // abort on 4th enable cycle, start while busy ignored
        v(1,1,0,0, 10,2,  1,1,0,0, 1);
        v(1,0,0,0, 0,0,   1,1,0,0, 1);
        v(1,1,0,0, 1,0,   1,1,0,0, 1);
        v(1,0,0,0, 0,0,   1,1,0,0, 1);
        v(1,0,1,0, 0,0,   0,0,0,1, 1);
        v(1,0,0,0, 0,0,   0,0,0,0, 1);
        v(1,0,1,0, 0,0,   0,0,0,0, 1);
        // reset mid-run
        v(1,1,0,0, 200,5, 1,1,0,0, 1);
        v(1,0,0,0, 0,0,   1,1,0,0, 1);
        v(0,0,0,0, 0,0,   0,0,0,0, 0);
        v(1,0,0,0, 0,0,   0,0,0,0, 0);
        // repeat, no gap: period 5, repeat dropped during third run
        v(1,1,0,1, 4,0,   1,1,0,0, 0);
        for (int i = 0; i < 3; i++) v(1,0,0,1, 0,0, 1,1,0,0, 0);
        v(1,0,0,1, 0,0,   0,1,0,0, 0);
        v(1,0,0,1, 0,0,   1,1,1,0, 1);
        for (int i = 0; i < 3; i++) v(1,0,0,1, 0,0, 1,1,0,0, 1);
        v(1,0,0,1, 0,0,   0,1,0,0, 1);
        v(1,0,0,1, 0,0,   1,1,1,0, 2);
        for (int i = 0; i < 3; i++) v(1,0,0,0, 0,0, 1,1,0,0, 2);
        v(1,0,0,0, 0,0,   0,0,1,0, 3);
        v(1,0,0,0, 0,0,   0,0,0,0, 3);
        // zero gap without repeat: done right after the run
        v(1,1,0,0, 2,0,   1,1,0,0, 3);
        v(1,0,0,0, 0,0,   1,1,0,0, 3);
        v(1,0,0,0, 0,0,   0,0,1,0, 4);
        v(1,0,0,0, 0,0,   0,0,0,0, 4);

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rstn, tv[i].st, tv[i].ab, tv[i].rep, tv[i].rl, tv[i].gl);
            check($sformatf("vec%0d", i), {enable, busy, done, aborted, run_count},
                  {tv[i].e_en, tv[i].e_busy, tv[i].e_done, tv[i].e_ab, tv[i].e_cnt});
        end

        // done latency N+G+1 with a bounded wait
        drive(1,1,0,0, 3,2);
        k = 0;
        for (int i = 1; i <= 50 && k == 0; i++) begin
            drive(1,0,0,0, 0,0);
            if (done) k = i;
        end
        check("done_latency", 12'(k), 12'd5);

        // saturation: 260 runs of length 1, gap 1
        dones = 0;
        for (int r = 0; r < 260; r++) begin
            drive(1,1,0,0, 1,1);
            for (int c = 0; c < 3; c++) begin
                drive(1,0,0,0, 0,0);
                if (done) dones++;
            end
        end
        check("sat_dones", 12'(dones), 12'd260);
        check("sat_count", {4'd0, run_count}, STATUS ? 12'd255 : 12'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
